// File: rtl/wb_pkg.sv
// Shared types for the register write-back block.
//   DATA_WIDTH / ADDR_WIDTH : default result and register-index widths
//   NUM_REGS                : register file size (register 0 is hard zero)
//   wb_entry_t              : buffered long-path result {dest, data}
//   wb_src_t                : which source owns the write port this cycle
package wb_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2**ADDR_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_FIFO, SRC_BYPASS} wb_src_t;
endpackage

// File: rtl/register_writeback_if.sv
// Bundle of all non-clock signals of register_writeback.
//   master : view of the write-back block (drives longReady, aluStall, the
//            register-file write port, busyMask, protocolError)
//   slave  : view of the surrounding pipeline / register file
interface register_writeback_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic                  aluValid;
  logic [ADDR_WIDTH-1:0] aluRegister;
  logic [DATA_WIDTH-1:0] aluData;
  logic                  longValid;
  logic                  longReady;
  logic [ADDR_WIDTH-1:0] longRegister;
  logic [DATA_WIDTH-1:0] longData;
  logic                  issueValid;
  logic [ADDR_WIDTH-1:0] issueRegister;
  logic                  aluStall;
  logic                  regWrite;
  logic [ADDR_WIDTH-1:0] writeRegister;
  logic [DATA_WIDTH-1:0] writeData;
  logic [NUM_REGS-1:0]   busyMask;
  logic                  protocolError;

  modport master (
    input  aluValid, aluRegister, aluData,
    input  longValid, longRegister, longData,
    input  issueValid, issueRegister,
    output longReady, aluStall, regWrite, writeRegister, writeData,
    output busyMask, protocolError
  );

  modport slave (
    output aluValid, aluRegister, aluData,
    output longValid, longRegister, longData,
    output issueValid, issueRegister,
    input  longReady, aluStall, regWrite, writeRegister, writeData,
    input  busyMask, protocolError
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer for long-path results waiting for the write port.
//   clock, reset : rising-edge clock, async active-high reset
//   push, din    : enqueue din (caller guarantees !full)
//   pop, head    : dequeue; head is the oldest entry (valid when !empty)
//   count        : occupancy 0..DEPTH; full / empty derived from it
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = wb_pkg::wb_entry_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/register_writeback.sv
// Write-side master of the register file. Merges the single-cycle ALU result
// and the handshaked long-latency result into one registered write port and
// tracks in-flight long writes in a per-register busy scoreboard.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (master) : ALU/long/issue inputs, longReady, aluStall, write port,
//                  busyMask, sticky protocolError
module register_writeback #(
  parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  register_writeback_if.master bus
);
  import wb_pkg::wb_src_t;
  import wb_pkg::SRC_NONE;
  import wb_pkg::SRC_ALU;
  import wb_pkg::SRC_FIFO;
  import wb_pkg::SRC_BYPASS;

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                din, head;
  logic [CW-1:0]         count, cnt_next;
  logic                  full, empty, push, pop;
  logic                  long_ok, alu_ok;
  wb_src_t               src;
  logic [ADDR_WIDTH-1:0] wr_dest;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_REGS-1:0]   clr, set, busy, busy_next;
  logic                  reg_write, stall, err;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;

  assign din = {bus.longRegister, bus.longData};

  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Ready comes from registered occupancy only, so there is no path from pop.
  assign bus.longReady = !full;
  // Register-0 long results are accepted but never stored or written.
  assign long_ok = bus.longValid && !full && (bus.longRegister != '0);
  assign alu_ok  = bus.aluValid && (bus.aluRegister != '0);

  // Priority: full FIFO drains first, then ALU, then buffered entries, then
  // a fresh long result straight through when nothing is queued.
  always_comb begin
    src  = SRC_NONE;
    push = 1'b0;
    pop  = 1'b0;
    if (full) begin
      src = SRC_FIFO;
      pop = 1'b1;
    end else if (alu_ok) begin
      src  = SRC_ALU;
      push = long_ok;
    end else if (!empty) begin
      src  = SRC_FIFO;
      pop  = 1'b1;
      push = long_ok;
    end else if (long_ok) begin
      src = SRC_BYPASS;
    end
  end

  always_comb begin
    wr_dest = bus.aluRegister;
    wr_data = bus.aluData;
    if (src == SRC_FIFO) begin
      wr_dest = head.dest;
      wr_data = head.data;
    end else if (src == SRC_BYPASS) begin
      wr_dest = bus.longRegister;
      wr_data = bus.longData;
    end
  end

  assign cnt_next = count + CW'(push) - CW'(pop);

  // Long writes retire their busy bit; a same-cycle issue re-sets it.
  assign clr = (src == SRC_FIFO || src == SRC_BYPASS) ? (NUM_REGS'(1) << wr_dest) : '0;
  assign set = bus.issueValid ? (NUM_REGS'(1) << bus.issueRegister) : '0;
  assign busy_next = ((busy & ~clr) | set) & ~NUM_REGS'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      busy       <= '0;
      stall      <= 1'b0;
      err        <= 1'b0;
    end else begin
      reg_write <= (src != SRC_NONE);
      if (src != SRC_NONE) begin
        write_reg  <= wr_dest;
        write_data <= wr_data;
      end
      busy  <= busy_next;
      stall <= (cnt_next == CW'(FIFO_DEPTH));
      // An ALU result offered while the FIFO owns the port is lost.
      err   <= err | (bus.aluValid && (stall || full));
    end
  end

  assign bus.regWrite      = reg_write;
  assign bus.writeRegister = write_reg;
  assign bus.writeData     = write_data;
  assign bus.busyMask      = busy;
  assign bus.aluStall      = stall;
  assign bus.protocolError = err;
endmodule

// File: tb/tb_register_writeback.sv
module tb_register_writeback;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  d;
    logic [31:0] v;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  register_writeback_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending long results as a queue, expected port state.
  ent_t        mq[$];
  logic [31:0] m_busy;
  logic        m_err, m_rw, m_acc;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  task automatic model_clear();
    mq.delete();
    m_busy = '0; m_err = 0; m_rw = 0; m_wr = '0; m_wd = '0; m_acc = 0;
  endtask

  // Drive one cycle of inputs (at negedge), advance the model, return at next negedge.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ir);
    bit   full, keep, long_wr;
    ent_t e;
    bus.aluValid = av; bus.aluRegister = ar; bus.aluData = ad;
    bus.longValid = lv; bus.longRegister = lr; bus.longData = ld;
    bus.issueValid = iv; bus.issueRegister = ir;
    full    = (mq.size() == DEPTH);
    m_acc   = lv && !full;
    keep    = m_acc && (lr != 0);
    long_wr = 0;
    m_rw    = 1;
    if (av && full) m_err = 1;
    if (full) begin
      e = mq.pop_front(); m_wr = e.d; m_wd = e.v; long_wr = 1;
    end else if (av && ar != 0) begin
      m_wr = ar; m_wd = ad;
      if (keep) mq.push_back('{lr, ld});
    end else if (mq.size() > 0) begin
      e = mq.pop_front(); m_wr = e.d; m_wd = e.v; long_wr = 1;
      if (keep) mq.push_back('{lr, ld});
    end else if (keep) begin
      m_wr = lr; m_wd = ld; long_wr = 1;
    end else begin
      m_rw = 0;
    end
    if (long_wr) m_busy[m_wr] = 1'b0;
    if (iv && ir != 0) m_busy[ir] = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    bus.aluValid = 0; bus.longValid = 0; bus.issueValid = 0;
    bus.aluRegister = 0; bus.aluData = 0; bus.longRegister = 0; bus.longData = 0;
    bus.issueRegister = 0;
    reset = 1;
    model_clear();
    #1;
    total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL reset_regWrite got=%b exp=0", bus.regWrite); end
    total++; if (bus.writeRegister !== 5'd0) begin bad++; $display("FAIL reset_writeRegister got=%0d exp=0", bus.writeRegister); end
    total++; if (bus.writeData !== 32'd0) begin bad++; $display("FAIL reset_writeData got=%h exp=0", bus.writeData); end
    total++; if (bus.busyMask !== 32'd0) begin bad++; $display("FAIL reset_busyMask got=%h exp=0", bus.busyMask); end
    total++; if (bus.aluStall !== 1'b0) begin bad++; $display("FAIL reset_aluStall got=%b exp=0", bus.aluStall); end
    total++; if (bus.protocolError !== 1'b0) begin bad++; $display("FAIL reset_protocolError got=%b exp=0", bus.protocolError); end
    total++; if (bus.longReady !== 1'b1) begin bad++; $display("FAIL reset_longReady got=%b exp=1", bus.longReady); end
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_alu();
    idle(); idle();
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    total++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd5 || bus.writeData !== 32'hDEADBEEF) begin
      bad++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/deadbeef", bus.regWrite, bus.writeRegister, bus.writeData);
    end
    idle();
    total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL alu_after got=%b exp=0", bus.regWrite); end
  endtask

  task automatic test_bypass();
    step(0, 0, 0, 0, 0, 0, 1, 7);
    total++; if (bus.busyMask[7] !== 1'b1) begin bad++; $display("FAIL bypass_busy_set got=%b exp=1", bus.busyMask[7]); end
    idle(); idle();
    total++; if (bus.busyMask[7] !== 1'b1) begin bad++; $display("FAIL bypass_busy_hold got=%b exp=1", bus.busyMask[7]); end
    step(0, 0, 0, 1, 7, 32'h12, 0, 0);
    total++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd7 || bus.writeData !== 32'h12) begin
      bad++; $display("FAIL bypass_write got=%b/%0d/%h exp=1/7/12", bus.regWrite, bus.writeRegister, bus.writeData);
    end
    total++; if (bus.busyMask[7] !== 1'b0) begin bad++; $display("FAIL bypass_busy_clr got=%b exp=0", bus.busyMask[7]); end
    idle();
  endtask

  task automatic test_same_cycle();
    step(1, 3, 32'hA3, 1, 4, 32'hB4, 0, 0);
    total++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd3 || bus.writeData !== 32'hA3) begin
      bad++; $display("FAIL same_alu got=%b/%0d/%h exp=1/3/a3", bus.regWrite, bus.writeRegister, bus.writeData);
    end
    idle();
    total++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd4 || bus.writeData !== 32'hB4) begin
      bad++; $display("FAIL same_long got=%b/%0d/%h exp=1/4/b4", bus.regWrite, bus.writeRegister, bus.writeData);
    end
    idle();
    total++; if (bus.regWrite !== 1'b0 || bus.longReady !== 1'b1 || mq.size() != 0) begin
      bad++; $display("FAIL same_drain got=%b/%b exp=0/1", bus.regWrite, bus.longReady);
    end
  endtask

  task automatic test_full();
    int got[$];
    int idx = 0;
    bit stall_seen = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) step(1, 1, 32'h100 + c, idx < 4, 5'(8 + idx), 32'h800 + idx, 0, 0);
      else idle();
      if (c < 8 && idx < 4 && m_acc) idx++;
      if (bus.aluStall === 1'b1) stall_seen = 1;
      if (bus.regWrite === 1'b1 && bus.writeRegister >= 8 && bus.writeRegister <= 11) got.push_back(int'(bus.writeRegister));
      total++; if (bus.regWrite !== m_rw || (m_rw && (bus.writeRegister !== m_wr || bus.writeData !== m_wd))) begin
        bad++; $display("FAIL full_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.regWrite, bus.writeRegister, bus.writeData, m_rw, m_wr, m_wd);
      end
      total++; if (bus.longReady !== (mq.size() < DEPTH) || bus.aluStall !== (mq.size() == DEPTH)) begin
        bad++; $display("FAIL full_flow cyc=%0d got=%b/%b exp=%b/%b", c, bus.longReady, bus.aluStall, mq.size() < DEPTH, mq.size() == DEPTH);
      end
    end
    total++; if (!stall_seen) begin bad++; $display("FAIL full_stall_seen got=0 exp=1"); end
    total++; if (bus.protocolError !== 1'b1) begin bad++; $display("FAIL full_protocolError got=%b exp=1", bus.protocolError); end
    total++; if (got.size() != 4 || got[0] != 8 || got[1] != 9 || got[2] != 10 || got[3] != 11) begin
      bad++; $display("FAIL full_order got=%p exp=8,9,10,11", got);
    end
  endtask

  task automatic test_zero();
    bit any_write = 0;
    bit any_busy0 = 0;
    bit any_notready = 0;
    for (int c = 0; c < 5; c++) begin
      step(1, 0, 32'h55, 1, 0, 32'h66, 1, 0);
      if (bus.regWrite !== 1'b0) any_write = 1;
      if (bus.busyMask[0] !== 1'b0) any_busy0 = 1;
      if (bus.longReady !== 1'b1) any_notready = 1;
    end
    total++; if (any_write) begin bad++; $display("FAIL zero_regWrite got=1 exp=0"); end
    total++; if (any_busy0) begin bad++; $display("FAIL zero_busy0 got=1 exp=0"); end
    total++; if (any_notready) begin bad++; $display("FAIL zero_longReady got=0 exp=1"); end
  endtask

  task automatic test_reset_mid();
    for (int r = 9; r <= 11; r++) step(0, 0, 0, 0, 0, 0, 1, 5'(r));
    for (int r = 9; r <= 11; r++) step(1, 1, 32'h1, 1, 5'(r), 32'h900 + r, 0, 0);
    total++; if (bus.busyMask !== 32'h0E00 || mq.size() != 3) begin
      bad++; $display("FAIL mid_setup busy got=%h exp=00000e00", bus.busyMask);
    end
    // Leave a write in flight, then hit reset mid-cycle.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1;
    #1;
    model_clear();
    total++; if (bus.regWrite !== 0 || bus.writeRegister !== 0 || bus.writeData !== 0 || bus.busyMask !== 0) begin
      bad++; $display("FAIL mid_reset_out got=%b/%0d/%h/%h exp=0/0/0/0", bus.regWrite, bus.writeRegister, bus.writeData, bus.busyMask);
    end
    total++; if (bus.longReady !== 1'b1 || bus.aluStall !== 1'b0) begin
      bad++; $display("FAIL mid_reset_flow got=%b/%b exp=1/0", bus.longReady, bus.aluStall);
    end
    @(negedge clock);
    reset = 0;
    for (int c = 0; c < 4; c++) begin
      idle();
      total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL mid_no_write cyc=%0d got=%b exp=0", c, bus.regWrite); end
    end
    step(0, 0, 0, 0, 0, 0, 1, 6);
    step(0, 0, 0, 1, 6, 32'h66, 1, 6);
    total++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd6 || bus.busyMask[6] !== 1'b1) begin
      bad++; $display("FAIL mid_set_wins got=%b/%0d/%b exp=1/6/1", bus.regWrite, bus.writeRegister, bus.busyMask[6]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1) == 0, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
      total++; if (bus.regWrite !== m_rw || (m_rw && (bus.writeRegister !== m_wr || bus.writeData !== m_wd))) begin
        bad++; $display("FAIL rand_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.regWrite, bus.writeRegister, bus.writeData, m_rw, m_wr, m_wd);
      end
      total++; if (bus.busyMask !== m_busy) begin
        bad++; $display("FAIL rand_busy cyc=%0d got=%h exp=%h", c, bus.busyMask, m_busy);
      end
      total++; if (bus.longReady !== (mq.size() < DEPTH) || bus.aluStall !== (mq.size() == DEPTH) || bus.protocolError !== m_err) begin
        bad++; $display("FAIL rand_flow cyc=%0d got=%b/%b/%b exp=%b/%b/%b", c, bus.longReady, bus.aluStall, bus.protocolError, mq.size() < DEPTH, mq.size() == DEPTH, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_bypass();
    test_same_cycle();
    test_full();
    test_zero();
    test_reset_mid();
    test_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_writeback.md
Name: register_writeback

Overview:
Write-side master for the `registers` file. It merges two result sources into the file's single write port: a single-cycle ALU path and a multi-cycle long-latency path (loads, mul/div) behind a valid/ready handshake. It keeps a per-register busy scoreboard for in-flight long operations, which the issue stage uses to stall on hazards. It sits between the execute/memory stages and the `registers` writeRegister/writeData port.

Parameters:
DATA_WIDTH, 32, width of writeData and of the result buses
ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers; register 0 is hard zero)
FIFO_DEPTH, 4, long-result buffer entries (power of 2, >= 2)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
aluValid  input  1  ALU result present this cycle (no backpressure)
aluRegister  input  ADDR_WIDTH  ALU destination register
aluData  input  DATA_WIDTH  ALU result
longValid  input  1  long-path result offered
longReady  output  1  long-path result accepted when high with longValid
longRegister  input  ADDR_WIDTH  long-path destination register
longData  input  DATA_WIDTH  long-path result
issueValid  input  1  a long op is issued this cycle
issueRegister  input  ADDR_WIDTH  destination register of the issued long op
aluStall  output  1  upstream must not present aluValid next cycle
regWrite  output  1  write enable to the register file
writeRegister  output  ADDR_WIDTH  write address to the register file
writeData  output  DATA_WIDTH  write data to the register file
busyMask  output  2**ADDR_WIDTH  bit i = register i has a pending long write
protocolError  output  1  sticky; set when aluValid arrives while aluStall=1

Behaviour:
- Reset (async, active-high):
  - Outputs go to these values: regWrite=0, writeRegister=0, writeData=0, busyMask=0, aluStall=0, protocolError=0.
  - FIFO is empty; longReady=1.
- Write port:
  - regWrite, writeRegister and writeData are registered.
  - Latency from the winning source cycle N to regWrite=1 is exactly 1 cycle (cycle N+1).
  - At most one write per cycle.
- Long path:
  - A transfer occurs when longValid && longReady.
  - longReady = (count < FIFO_DEPTH). It depends only on registered count; there is no combinational path from pop.
  - A transfer with longRegister=0 is accepted and discarded. It is never stored and never written.
- Arbitration, evaluated each cycle:
  - count==FIFO_DEPTH: the FIFO head wins. The head is popped and written.
  - Otherwise, if aluValid && aluRegister!=0: the ALU wins. The FIFO holds.
  - Otherwise, if the FIFO is non-empty: the head is popped and written.
  - Otherwise, if a long transfer is accepted this cycle with longRegister!=0: it bypasses the FIFO (push and pop in the same cycle, count unchanged) and is written at N+1.
  - Otherwise: regWrite=0 next cycle.
  - aluValid with aluRegister=0 produces no write.
- aluStall:
  - Registered. aluStall = 1 in cycle N+1 iff count==FIFO_DEPTH after the edge ending cycle N.
  - If aluValid=1 while aluStall=1 (or in the full-priority cycle), the ALU result is dropped and protocolError is set.
  - protocolError clears only on reset.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by construction of longReady.
- busyMask:
  - Set bit i at the edge when issueValid && issueRegister==i && i!=0.
  - Clear bit i at the same edge that drives regWrite=1 for a long-path result with writeRegister==i.
  - Set and clear of the same bit in the same cycle: set wins (new issue).
  - ALU writes never modify busyMask.
  - Bit 0 is constant 0.
- Reset mid-operation: FIFO contents, pending busy bits and any write in flight are discarded immediately. No write is issued after reset deasserts until a new source arrives.

Decomposition:
- Package wb_pkg:
  - DATA_WIDTH/ADDR_WIDTH defaults
  - NUM_REGS = 2**ADDR_WIDTH
  - typedef wb_entry_t {dest[ADDR_WIDTH], data[DATA_WIDTH]}
  - enum wb_src_t {SRC_NONE, SRC_ALU, SRC_FIFO, SRC_BYPASS}
- One sub-module, wb_fifo:
  - Parameterised FIFO of wb_entry_t.
  - Ports: push, pop, head, count, full, empty.
- Arbitration, scoreboard and output registers stay in register_writeback.

Test Plan:
1. Reset, then aluValid=1, aluRegister=5, aluData=0xDEADBEEF in cycle 3 -> cycle 4: regWrite=1, writeRegister=5, writeData=0xDEADBEEF; cycle 5: regWrite=0.
2. issueValid with issueRegister=7; three cycles later longValid with longRegister=7, data 0x12, no ALU activity -> busyMask[7]=1 until the edge where regWrite=1, writeRegister=7, writeData=0x12 (bypass, 1-cycle latency); busyMask[7]=0 in that same cycle.
3. aluValid and longValid in the same cycle (regs 3 and 4) -> reg 3 is written at N+1 and reg 4 at N+2; count returns to 0.
4. aluValid every cycle with dest 1, plus 4 long results (dests 8..11) -> FIFO fills, longReady=0, aluStall=1 the next cycle; head 8 is written despite aluValid; protocolError=1; all of 8..11 are eventually written in order.
5. Writes to register 0 on both paths and issueRegister=0 -> regWrite never asserts; busyMask[0] stays 0; longReady stays 1.
6. Assert reset with 3 FIFO entries pending and busyMask=0x0E00 -> outputs, count and busyMask read 0 immediately; no write follows deassertion; issue and complete of the same register in the same cycle leave the bit set.
